// File: rtl/memory_model.sv
// memory_model
// Sparse single-port memory used as a storage endpoint behind bus-functional
// models. Only written addresses occupy a slot; slots are allocated in order
// and are never freed except by reset, so slot i holds a live entry exactly
// when i < entry_count. Lookup is a parallel compare over the live slots.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset, clears every entry
//   wr_en        write strobe
//   rd_en        read strobe
//   addr         shared read/write address (unsigned)
//   wdata        write data
//   rdata        registered read data, holds when rd_en=0
//   rd_hit       registered, 1 when the last read found a stored entry
//   entry_count  number of stored addresses
//   overflow     sticky, set when a write to a new address is dropped (full)
module memory_model #(
    parameter int                 ADDR_W       = 32,
    parameter int                 DATA_W       = 32,
    parameter logic [DATA_W-1:0]  DEFAULT_DATA = '0,
    parameter int                 MAX_ENTRIES  = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_en,
    input  logic                                 rd_en,
    input  logic [ADDR_W-1:0]                    addr,
    input  logic [DATA_W-1:0]                    wdata,
    output logic [DATA_W-1:0]                    rdata,
    output logic                                 rd_hit,
    output logic [$clog2(MAX_ENTRIES+1)-1:0]     entry_count,
    output logic                                 overflow
);

    localparam int CNT_W = $clog2(MAX_ENTRIES + 1);
    localparam int IDX_W = (MAX_ENTRIES > 1) ? $clog2(MAX_ENTRIES) : 1;

    logic [ADDR_W-1:0] entry_addr [MAX_ENTRIES];
    logic [DATA_W-1:0] entry_data [MAX_ENTRIES];

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             full;
    logic [IDX_W-1:0] free_idx;
    logic             addr_known;
    logic             wdata_known;
    logic             rd_ok;
    logic             wr_ok;

    // Unknown address or write data turns the operation into a no-op.
    assign addr_known  = !$isunknown(addr);
    assign wdata_known = !$isunknown(wdata);
    assign rd_ok       = rd_en && addr_known;
    assign wr_ok       = wr_en && addr_known && wdata_known;

    assign full     = (entry_count == CNT_W'(MAX_ENTRIES));
    assign free_idx = IDX_W'(entry_count);

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < MAX_ENTRIES; i++) begin
            if (!hit && (CNT_W'(i) < entry_count) && (entry_addr[i] == addr)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Read uses pre-edge storage, which gives read-before-write on a
    // same-cycle read and write to one address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata       <= '0;
            rd_hit      <= 1'b0;
            entry_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (rd_ok) begin
                rd_hit <= hit;
                rdata  <= hit ? entry_data[hit_idx] : DEFAULT_DATA;
            end
            if (wr_ok && !hit) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    entry_count <= entry_count + CNT_W'(1);
                end
            end
        end
    end

    // Slot contents need no reset: entry_count going to zero invalidates them.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            if (hit) begin
                entry_data[hit_idx] <= wdata;
            end else if (!full) begin
                entry_addr[free_idx] <= addr;
                entry_data[free_idx] <= wdata;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && (rd_en || wr_en) && !addr_known)
            $warning("memory_model: unknown addr, operation ignored");
        if (rst_n && wr_en && addr_known && !wdata_known)
            $warning("memory_model: unknown wdata, write ignored");
    end
`endif

endmodule

// File: tb/tb_memory_model.sv
module tb_memory_model;

    localparam int               ADDR_W = 8;
    localparam int               DATA_W = 16;
    localparam logic [DATA_W-1:0] DEF   = 16'h00A5;
    localparam int               MAXE   = 4;
    localparam int               CNT_W  = $clog2(MAXE + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en, rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rd_hit;
    logic [CNT_W-1:0]  entry_count;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    memory_model #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEFAULT_DATA(DEF), .MAX_ENTRIES(MAXE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .rd_hit(rd_hit), .entry_count(entry_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: associative array keyed by address.
    logic [DATA_W-1:0] mem [int];
    logic [DATA_W-1:0] m_rdata;
    logic              m_hit;
    logic              m_ovf;

    task automatic model_reset();
        mem.delete();
        m_rdata = '0;
        m_hit   = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step(input bit we, input bit re, input int a, input logic [DATA_W-1:0] d);
        if (re) begin
            m_hit   = mem.exists(a);
            m_rdata = m_hit ? mem[a] : DEF;
        end
        if (we) begin
            if (mem.exists(a))          mem[a] = d;
            else if (mem.num() < MAXE)  mem[a] = d;
            else                        m_ovf  = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input bit we, input bit re, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        wr_en = we; rd_en = re; addr = a; wdata = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".rdata"},  32'(rdata),       32'(m_rdata));
        check({tag, ".rd_hit"}, 32'(rd_hit),      32'(m_hit));
        check({tag, ".count"},  32'(entry_count), 32'(mem.num()));
        check({tag, ".ovf"},    32'(overflow),    32'(m_ovf));
    endtask

    typedef struct {
        bit                we;
        bit                re;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] e_rdata;
        bit                e_hit;
        int                e_count;
        bit                e_ovf;
    } vec_t;

    vec_t vecs [17];

    initial begin
        vecs[0]  = '{1, 0,  10,  55,   0, 0, 1, 0};
        vecs[1]  = '{1, 0,  99, 200,   0, 0, 2, 0};
        vecs[2]  = '{0, 1,  10,   0,  55, 1, 2, 0};
        vecs[3]  = '{0, 1,  99,   0, 200, 1, 2, 0};
        vecs[4]  = '{0, 1,  42,   0, DEF, 0, 2, 0};
        vecs[5]  = '{1, 0,  10,   7, DEF, 0, 2, 0};
        vecs[6]  = '{0, 1,  10,   0,   7, 1, 2, 0};
        vecs[7]  = '{1, 0,   5,   3,   7, 1, 3, 0};
        vecs[8]  = '{1, 1,   5,   9,   3, 1, 3, 0};
        vecs[9]  = '{0, 1,   5,   0,   9, 1, 3, 0};
        vecs[10] = '{1, 1,  77,   1, DEF, 0, 4, 0};
        vecs[11] = '{0, 1,  77,   0,   1, 1, 4, 0};
        vecs[12] = '{1, 0, 200,   2,   1, 1, 4, 1};
        vecs[13] = '{0, 1, 200,   0, DEF, 0, 4, 1};
        vecs[14] = '{1, 0,  10,   8, DEF, 0, 4, 1};
        vecs[15] = '{0, 1,  10,   0,   8, 1, 4, 1};
        vecs[16] = '{0, 0,  10,   0,   8, 1, 4, 1};

        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset.rdata",  32'(rdata),       0);
        check("reset.rd_hit", 32'(rd_hit),      0);
        check("reset.count",  32'(entry_count), 0);
        check("reset.ovf",    32'(overflow),    0);

        for (int i = 0; i < 17; i++) begin
            cycle(vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].d);
            check($sformatf("vec%0d.rdata", i),  32'(rdata),       32'(vecs[i].e_rdata));
            check($sformatf("vec%0d.rd_hit", i), 32'(rd_hit),      32'(vecs[i].e_hit));
            check($sformatf("vec%0d.count", i),  32'(entry_count), 32'(vecs[i].e_count));
            check($sformatf("vec%0d.ovf", i),    32'(overflow),    32'(vecs[i].e_ovf));
        end

        // Asynchronous reset between edges, with a write strobe held through it.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.rdata",  32'(rdata),       0);
        check("async_rst.rd_hit", 32'(rd_hit),      0);
        check("async_rst.count",  32'(entry_count), 0);
        check("async_rst.ovf",    32'(overflow),    0);
        wr_en = 1'b1; addr = 8'd10; wdata = 16'h1234;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check("rst_hold.count", 32'(entry_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 1, 8'd10, 0);
        check("post_rst10.rdata",  32'(rdata),  32'(DEF));
        check("post_rst10.rd_hit", 32'(rd_hit), 0);
        cycle(0, 1, 8'd77, 0);
        check("post_rst77.rdata",  32'(rdata),  32'(DEF));
        check("post_rst77.rd_hit", 32'(rd_hit), 0);
        check("post_rst.count",    32'(entry_count), 0);

        // Randomized traffic against the reference model, with periodic resets.
        model_reset();
        for (int n = 0; n < 600; n++) begin
            if (n % 97 == 96) begin
                @(negedge clk);
                rst_n = 1'b0;
                model_reset();
                #1;
                check_model("rnd_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                bit we, re;
                logic [ADDR_W-1:0] a;
                logic [DATA_W-1:0] d;
                we = ($urandom_range(0, 2) != 0);
                re = ($urandom_range(0, 1) != 0);
                a  = ADDR_W'($urandom_range(0, 7));
                d  = DATA_W'($urandom);
                model_step(we, re, int'(a), d);
                cycle(we, re, a, d);
                check_model($sformatf("rnd%0d", n));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
